// File: rtl/btb_pkg.sv
// Shared constants and helpers for the set-associative branch target buffer:
// saturating counter step and PC index/tag extraction.
package btb_pkg;

    localparam int CTR_W_MAX      = 8;
    localparam int CTR_W_DEFAULT  = 2;
    localparam int CTR_WEAK_TAKEN = 2 ** (CTR_W_DEFAULT - 1);

    function automatic logic [CTR_W_MAX-1:0] ctr_step(input logic [CTR_W_MAX-1:0] ctr,
                                                      input logic up,
                                                      input int unsigned w);
        logic [CTR_W_MAX-1:0] ctr_max;
        ctr_max = CTR_W_MAX'((9'd1 << w) - 9'd1);
        if (up)
            return (ctr == ctr_max) ? ctr : ctr + 1'b1;
        else
            return (ctr == '0) ? ctr : ctr - 1'b1;
    endfunction

    function automatic logic [31:0] pc_index(input logic [31:0] pc, input int unsigned index_w);
        return (pc >> 2) & ((32'd1 << index_w) - 32'd1);
    endfunction

    function automatic logic [31:0] pc_tag(input logic [31:0] pc, input int unsigned index_w,
                                           input int unsigned tag_w);
        return (pc >> (index_w + 2)) & ((32'd1 << tag_w) - 32'd1);
    endfunction

endpackage

// File: rtl/btb_way.sv
// One BTB way: valid/tag/target/counter arrays with a lookup read port, an update
// read port and a single write port addressed by the update index. Reads are combinational.
module btb_way #(
    parameter int INDEX_W = 6,
    parameter int TAG_W   = 12,
    parameter int CTR_W   = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_i,
    input  logic [INDEX_W-1:0] lk_idx_i,
    input  logic [TAG_W-1:0]   lk_tag_i,
    output logic               lk_hit_o,
    output logic [31:0]        lk_tgt_o,
    output logic [CTR_W-1:0]   lk_ctr_o,
    input  logic [INDEX_W-1:0] up_idx_i,
    input  logic [TAG_W-1:0]   up_tag_i,
    output logic               up_hit_o,
    output logic               up_vld_o,
    output logic [CTR_W-1:0]   up_ctr_o,
    input  logic               alloc_i,
    input  logic               ctr_we_i,
    input  logic [CTR_W-1:0]   ctr_i,
    input  logic               tgt_we_i,
    input  logic [31:0]        tgt_i
);
    localparam int SETS = 2 ** INDEX_W;

    logic [SETS-1:0]  valid_q;
    logic [CTR_W-1:0] ctr_q [SETS];
    logic [TAG_W-1:0] tag_q [SETS];
    logic [31:0]      tgt_q [SETS];

    assign lk_hit_o = valid_q[lk_idx_i] && (tag_q[lk_idx_i] == lk_tag_i);
    assign lk_tgt_o = tgt_q[lk_idx_i];
    assign lk_ctr_o = ctr_q[lk_idx_i];

    assign up_vld_o = valid_q[up_idx_i];
    assign up_hit_o = valid_q[up_idx_i] && (tag_q[up_idx_i] == up_tag_i);
    assign up_ctr_o = ctr_q[up_idx_i];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
            for (int s = 0; s < SETS; s++) ctr_q[s] <= '0;
        end else begin
            if (flush_i)
                valid_q <= '0;
            else if (alloc_i)
                valid_q[up_idx_i] <= 1'b1;
            if (ctr_we_i)
                ctr_q[up_idx_i] <= ctr_i;
        end
    end

    // Tag and target are only meaningful behind a valid bit, so they carry no reset.
    always_ff @(posedge clk_i) begin
        if (alloc_i)
            tag_q[up_idx_i] <= up_tag_i;
        if (tgt_we_i)
            tgt_q[up_idx_i] <= tgt_i;
    end

endmodule

// File: rtl/btb_assoc.sv
// Set-associative BTB: zero-cycle lookup for fetch, one resolved-branch update per
// cycle (no backpressure), round-robin eviction per set, synchronous flush.
module btb_assoc
    import btb_pkg::*;
#(
    parameter int INDEX_W = 6,
    parameter int WAYS    = 2,
    parameter int TAG_W   = 12,
    parameter int CTR_W   = CTR_W_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] lookup_PC,
    output logic        BTB_hit,
    output logic [31:0] BTB_PC,
    output logic        predict_taken,
    input  logic        is_branch_inst,
    input  logic [31:0] resolved_Branch_PC,
    input  logic [31:0] destination_PC,
    input  logic        resolved_taken,
    input  logic        flush
);
    localparam int SETS = 2 ** INDEX_W;
    localparam int RR_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam logic [CTR_W-1:0] WEAK_TAKEN = CTR_W'(1 << (CTR_W - 1));

    logic [INDEX_W-1:0] lk_idx, up_idx;
    logic [TAG_W-1:0]   lk_tag, up_tag;

    assign lk_idx = INDEX_W'(pc_index(lookup_PC, INDEX_W));
    assign lk_tag = TAG_W'(pc_tag(lookup_PC, INDEX_W, TAG_W));
    assign up_idx = INDEX_W'(pc_index(resolved_Branch_PC, INDEX_W));
    assign up_tag = TAG_W'(pc_tag(resolved_Branch_PC, INDEX_W, TAG_W));

    logic [WAYS-1:0]  lk_hit, up_hit, up_vld, alloc, ctr_we, tgt_we;
    logic [31:0]      lk_tgt [WAYS];
    logic [CTR_W-1:0] lk_ctr [WAYS];
    logic [CTR_W-1:0] up_ctr [WAYS];
    logic [CTR_W-1:0] ctr_wr;
    logic [RR_W-1:0]  rr_q [SETS];
    logic [RR_W-1:0]  rr_d;

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        btb_way #(.INDEX_W(INDEX_W), .TAG_W(TAG_W), .CTR_W(CTR_W)) u_way (
            .clk_i(clk), .rst_i(rst), .flush_i(flush),
            .lk_idx_i(lk_idx), .lk_tag_i(lk_tag),
            .lk_hit_o(lk_hit[w]), .lk_tgt_o(lk_tgt[w]), .lk_ctr_o(lk_ctr[w]),
            .up_idx_i(up_idx), .up_tag_i(up_tag),
            .up_hit_o(up_hit[w]), .up_vld_o(up_vld[w]), .up_ctr_o(up_ctr[w]),
            .alloc_i(alloc[w]), .ctr_we_i(ctr_we[w]), .ctr_i(ctr_wr),
            .tgt_we_i(tgt_we[w]), .tgt_i(destination_PC)
        );
    end

    // Lookup priority mux: iterate high to low so the lowest matching way wins.
    always_comb begin
        BTB_hit       = 1'b0;
        BTB_PC        = '0;
        predict_taken = 1'b0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (lk_hit[w]) begin
                BTB_hit       = 1'b1;
                BTB_PC        = lk_tgt[w];
                predict_taken = lk_ctr[w][CTR_W-1];
            end
        end
    end

    logic            upd, up_hit_any, free_any, rr_adv;
    logic [RR_W-1:0] up_sel, free_sel, victim;
    logic [CTR_W-1:0] up_ctr_sel;

    assign upd = is_branch_inst && !flush;

    always_comb begin
        up_hit_any = 1'b0;
        up_sel     = '0;
        up_ctr_sel = '0;
        free_any   = 1'b0;
        free_sel   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (up_hit[w]) begin
                up_hit_any = 1'b1;
                up_sel     = RR_W'(w);
                up_ctr_sel = up_ctr[w];
            end
            if (!up_vld[w]) begin
                free_any = 1'b1;
                free_sel = RR_W'(w);
            end
        end
    end

    assign victim = free_any ? free_sel : rr_q[up_idx];
    assign ctr_wr = up_hit_any ? CTR_W'(ctr_step(CTR_W_MAX'(up_ctr_sel), resolved_taken, CTR_W))
                               : WEAK_TAKEN;

    always_comb begin
        alloc  = '0;
        ctr_we = '0;
        tgt_we = '0;
        for (int w = 0; w < WAYS; w++) begin
            alloc[w]  = upd && !up_hit_any && resolved_taken && (victim == RR_W'(w));
            ctr_we[w] = (upd && up_hit_any && (up_sel == RR_W'(w))) || alloc[w];
            tgt_we[w] = ctr_we[w] && resolved_taken;
        end
    end

    // The pointer only moves when a live entry is displaced, not when filling a hole.
    assign rr_adv = upd && !up_hit_any && resolved_taken && !free_any;
    assign rr_d   = (rr_q[up_idx] == RR_W'(WAYS - 1)) ? '0 : rr_q[up_idx] + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
        end else if (flush) begin
            for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
        end else if (rr_adv) begin
            rr_q[up_idx] <= rr_d;
        end
    end

endmodule

// File: tb/tb_btb_assoc.sv
// Directed bench for btb_assoc with default parameters (64 sets, 2 ways, 12-bit tag).
module tb_btb_assoc;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] lookup_PC;
    logic        BTB_hit;
    logic [31:0] BTB_PC;
    logic        predict_taken;
    logic        is_branch_inst;
    logic [31:0] resolved_Branch_PC;
    logic [31:0] destination_PC;
    logic        resolved_taken;
    logic        flush;

    int checks   = 0;
    int failures = 0;

    btb_assoc dut (
        .clk(clk), .rst(rst), .lookup_PC(lookup_PC), .BTB_hit(BTB_hit), .BTB_PC(BTB_PC),
        .predict_taken(predict_taken), .is_branch_inst(is_branch_inst),
        .resolved_Branch_PC(resolved_Branch_PC), .destination_PC(destination_PC),
        .resolved_taken(resolved_taken), .flush(flush)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic lk(input string tag, input logic [31:0] pc, input logic hit,
                      input logic [31:0] tgt, input logic pt);
        lookup_PC = pc;
        #1;
        check({tag, ".hit"}, {31'd0, BTB_hit}, {31'd0, hit});
        check({tag, ".pc"}, BTB_PC, tgt);
        check({tag, ".pt"}, {31'd0, predict_taken}, {31'd0, pt});
    endtask

    task automatic upd(input logic [31:0] pc, input logic [31:0] dest, input logic taken,
                       input logic fl);
        @(negedge clk);
        is_branch_inst     = 1'b1;
        resolved_Branch_PC = pc;
        destination_PC     = dest;
        resolved_taken     = taken;
        flush              = fl;
        @(negedge clk);
        is_branch_inst     = 1'b0;
        flush              = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        lookup_PC = 32'h1000;
        is_branch_inst = 1'b0;
        resolved_Branch_PC = '0;
        destination_PC = '0;
        resolved_taken = 1'b0;
        flush = 1'b0;
        #2;
        lk("in_reset", 32'h1000, 1'b0, 32'h0, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        lk("after_reset", 32'h1000, 1'b0, 32'h0, 1'b0);

        // first allocation goes to way 0, counter weakly taken
        upd(32'h1000, 32'h2000, 1'b1, 1'b0);
        lk("alloc1", 32'h1000, 1'b1, 32'h2000, 1'b1);
        lk("alloc1_lowbits", 32'h1002, 1'b1, 32'h2000, 1'b1);
        lk("other_set", 32'h1004, 1'b0, 32'h0, 1'b0);

        upd(32'h2000, 32'hA000, 1'b1, 1'b0);
        lk("alias_a", 32'h1000, 1'b1, 32'h2000, 1'b1);
        lk("alias_b", 32'h2000, 1'b1, 32'hA000, 1'b1);

        // set full: evicts way 0 (rr=0), then way 1 (rr=1, wraps back to 0)
        upd(32'h3000, 32'hB000, 1'b1, 1'b0);
        lk("evict0_gone", 32'h1000, 1'b0, 32'h0, 1'b0);
        lk("evict0_new", 32'h3000, 1'b1, 32'hB000, 1'b1);
        lk("evict0_keep", 32'h2000, 1'b1, 32'hA000, 1'b1);
        upd(32'h4000, 32'hC000, 1'b1, 1'b0);
        lk("evict1_gone", 32'h2000, 1'b0, 32'h0, 1'b0);
        lk("evict1_new", 32'h4000, 1'b1, 32'hC000, 1'b1);
        lk("evict1_keep", 32'h3000, 1'b1, 32'hB000, 1'b1);

        // rr wrapped to 0: re-allocating 0x1000 displaces 0x3000
        upd(32'h1000, 32'h2000, 1'b1, 1'b0);
        lk("wrap_new", 32'h1000, 1'b1, 32'h2000, 1'b1);
        lk("wrap_gone", 32'h3000, 1'b0, 32'h0, 1'b0);

        // counter 2->1->0; target kept on not-taken
        upd(32'h1000, 32'h9999, 1'b0, 1'b0);
        lk("ctr1", 32'h1000, 1'b1, 32'h2000, 1'b0);
        upd(32'h1000, 32'h9999, 1'b0, 1'b0);
        lk("ctr0", 32'h1000, 1'b1, 32'h2000, 1'b0);
        upd(32'h1000, 32'h9999, 1'b0, 1'b0);
        lk("ctr0_floor", 32'h1000, 1'b1, 32'h2000, 1'b0);
        // 0->1->2->3->3; target follows latest taken dest
        upd(32'h1000, 32'h2100, 1'b1, 1'b0);
        lk("ctr_up1", 32'h1000, 1'b1, 32'h2100, 1'b0);
        upd(32'h1000, 32'h2200, 1'b1, 1'b0);
        lk("ctr_up2", 32'h1000, 1'b1, 32'h2200, 1'b1);
        upd(32'h1000, 32'h2300, 1'b1, 1'b0);
        upd(32'h1000, 32'h2400, 1'b1, 1'b0);
        lk("ctr_sat", 32'h1000, 1'b1, 32'h2400, 1'b1);
        upd(32'h1000, 32'h9999, 1'b0, 1'b0);
        lk("ctr_sat_dn2", 32'h1000, 1'b1, 32'h2400, 1'b1);
        upd(32'h1000, 32'h9999, 1'b0, 1'b0);
        lk("ctr_sat_dn1", 32'h1000, 1'b1, 32'h2400, 1'b0);
        upd(32'h1000, 32'h2400, 1'b1, 1'b0);
        upd(32'h1000, 32'h2400, 1'b1, 1'b0);

        // not-taken miss leaves everything alone
        upd(32'h5000, 32'hD000, 1'b0, 1'b0);
        lk("nt_miss", 32'h5000, 1'b0, 32'h0, 1'b0);
        lk("nt_miss_keep", 32'h4000, 1'b1, 32'hC000, 1'b1);

        // same-cycle lookup sees old contents, next cycle the new target
        @(negedge clk);
        is_branch_inst = 1'b1;
        resolved_Branch_PC = 32'h1000;
        destination_PC = 32'h7000;
        resolved_taken = 1'b1;
        lk("bypass_old", 32'h1000, 1'b1, 32'h2400, 1'b1);
        @(negedge clk);
        is_branch_inst = 1'b0;
        lk("bypass_new", 32'h1000, 1'b1, 32'h7000, 1'b1);

        // flush with a concurrent update: all gone, update dropped
        upd(32'h6000, 32'hE000, 1'b1, 1'b1);
        lk("flush_a", 32'h1000, 1'b0, 32'h0, 1'b0);
        lk("flush_b", 32'h4000, 1'b0, 32'h0, 1'b0);
        lk("flush_drop", 32'h6000, 1'b0, 32'h0, 1'b0);

        // rr reset by flush: third alias evicts way 0 (0x1000), not way 1
        upd(32'h1000, 32'h1100, 1'b1, 1'b0);
        upd(32'h2000, 32'h2200, 1'b1, 1'b0);
        upd(32'h3000, 32'h3300, 1'b1, 1'b0);
        lk("rr_flush_gone", 32'h1000, 1'b0, 32'h0, 1'b0);
        lk("rr_flush_keep", 32'h2000, 1'b1, 32'h2200, 1'b1);
        lk("rr_flush_new", 32'h3000, 1'b1, 32'h3300, 1'b1);

        // async reset mid-cycle clears outputs immediately
        @(posedge clk);
        #2;
        rst = 1'b1;
        lk("async_rst", 32'h2000, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        lk("post_rst", 32'h3000, 1'b0, 32'h0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/btb_assoc.md
# btb_assoc

Parametrised set-associative branch target buffer. It replaces the direct-mapped, untagged target table in the fetch stage. Adds per-entry tags, valid bits, 2-bit taken/not-taken counters, multi-way sets with round-robin replacement, and a synchronous flush. Fetch gets a same-cycle lookup (hit, target, taken prediction); the branch-resolution stage writes back outcomes one update per cycle.

## Interface
- INDEX_W, 6: set index bits; SETS = 2**INDEX_W.
- WAYS, 2: ways per set; power of two, 1..8.
- TAG_W, 12: stored tag bits; INDEX_W+TAG_W+2 <= 32.
- CTR_W, 2: saturating counter width.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset; **one clock; reset is asynchronous and active-high**.
- lookup_PC  input  32  fetch PC to predict.
- BTB_hit  output  1  valid tag match for lookup_PC.
- BTB_PC  output  32  predicted target; 0 when BTB_hit=0.
- predict_taken  output  1  BTB_hit & counter MSB.
- is_branch_inst  input  1  update strobe from resolution stage.
- resolved_Branch_PC  input  32  PC of the resolved branch/jump.
- destination_PC  input  32  resolved target.
- resolved_taken  input  1  actual outcome (1 for jal/jalr).
- flush  input  1  synchronous invalidate-all.

## Operation
- Address split: index = PC[INDEX_W+1:2]; tag = PC[INDEX_W+TAG_W+1:INDEX_W+2]; PC[1:0] ignored.
- Lookup is combinational. It compares the tag against all valid ways of the indexed set. On multiple matches the lowest way wins; a legal update sequence never produces multiple matches.
- Update, when is_branch_inst=1 and flush=0:
  - Hit in way w: counter saturates up if resolved_taken, down otherwise (0 and 2**CTR_W-1 are the limits). Target is rewritten with destination_PC only if resolved_taken. Valid and tag are unchanged.
  - Miss, resolved_taken=1: allocate a way. Use the lowest invalid way if one exists; otherwise use the set's round-robin pointer rr[set]. Write valid=1, tag, target=destination_PC, counter=weakly-taken (2**(CTR_W-1)). rr[set] advances by 1, wrapping at WAYS, only when a valid way is evicted.
  - Miss, resolved_taken=0: no state change.
- flush=1: all valid bits and all rr pointers clear next edge. Any same-cycle update is dropped.
- Reset: valid bits, counters, and rr pointers are cleared. Tag and target arrays need no reset; they are unobservable while valid=0.

## Timing
- Lookup latency is 0 cycles (combinational from lookup_PC and current state).
- An update is visible to lookup from the cycle after its clock edge. A same-cycle lookup of the same set sees the old contents; there is no bypass.
- Throughput is one update per cycle. Back-to-back updates to the same entry apply sequentially; the counter steps once per update.
- Outputs during and immediately after reset: BTB_hit=0, BTB_PC=0, predict_taken=0.
- Reset asserted mid-operation overrides any update or flush in progress.

## Structure
- btb_pkg holds:
  - counter-width constants;
  - CTR_WEAK_TAKEN;
  - a saturating increment/decrement function;
  - the index/tag extraction functions, parameterised by INDEX_W/TAG_W.
- Sub-module btb_way, instantiated WAYS times, holds:
  - valid/tag/target/counter arrays;
  - match logic for lookup and for update;
  - a write port.
- The top level holds:
  - way select (priority mux);
  - victim choice;
  - rr pointers;
  - flush handling.

## Test plan
- Reset, then lookup 0x0000_1000 → BTB_hit=0, BTB_PC=0, predict_taken=0.
- Taken update PC=0x1000 → dest 0x2000; next cycle lookup 0x1000 → hit, BTB_PC=0x2000, predict_taken=1 (counter=2).
- Alias test:
  - Taken updates at 0x1000 and 0x2000 (same index, different tags): both hit with their own targets.
  - A third alias, 0x3000, evicts way 0.
  - A fourth alias, 0x4000, evicts way 1 (rr wrap).
- Two not-taken updates to 0x1000 (counter 2→1→0) → hit=1, predict_taken=0. Three taken updates → counter saturates at 3, and target is updated to the latest dest.
- Not-taken update to absent PC 0x5000 → still miss. An update in the same cycle as flush=1 → everything misses afterwards.
- Same-cycle lookup and update of 0x1000 → the old value is seen that cycle and the new value the next cycle. Async rst asserted mid-stream → outputs go to 0 immediately.
